// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes and decode helpers.
// Op codes match the `MD_* values driven by the E-stage decode of ir_E.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMthi  = 4'd5,
        MdMtlo  = 4'd6
    } md_op_e;

    localparam int unsigned CountWidth = 4;

    // Multi-cycle ops occupy the unit and must stall younger md instructions.
    function automatic logic md_is_long(input md_op_e op);
        return op inside {MdMult, MdMultu, MdDiv, MdDivu};
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return op inside {MdDiv, MdDivu};
    endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO. The result is computed combinationally at issue,
// parked in hi_pend/lo_pend, and committed when the busy countdown expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CountWidth-1:0] MultCount = CountWidth'(MULT_CYCLES);
    localparam logic [CountWidth-1:0] DivCount  = CountWidth'(DIV_CYCLES);

    md_op_e op;
    assign op = md_op_e'(md_op);

    logic [CountWidth-1:0] count_q;
    logic [31:0]           hi_pend_q, lo_pend_q;
    logic                  pend_wr_q;

    assign md_stall = busy | (start & md_is_long(op));

    // Products: sign- or zero-extend to 64 bits so the low 64 bits of the product are exact.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign a_neg      = a[31];
    assign b_neg      = b[31];
    assign b_zero     = (b == 32'd0);
    assign a_mag      = a_neg ? (32'd0 - a) : a;
    assign b_mag      = b_neg ? (32'd0 - b) : b;
    assign b_safe     = b_zero ? 32'd1 : b;
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign r_s        = a_neg ? (32'd0 - r_mag) : r_mag;
    assign q_u        = a / b_safe;
    assign r_u        = a % b_safe;

    logic [31:0]           res_hi, res_lo;
    logic                  res_wr;
    logic [CountWidth-1:0] res_count;

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_wr    = 1'b0;
        res_count = md_is_div(op) ? DivCount : MultCount;
        unique case (op)
            MdMult: begin
                {res_hi, res_lo} = prod_s;
                res_wr           = 1'b1;
            end
            MdMultu: begin
                {res_hi, res_lo} = prod_u;
                res_wr           = 1'b1;
            end
            MdDiv: begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = ~b_zero;
            end
            MdDivu: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = ~b_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            busy      <= 1'b0;
            count_q   <= '0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else if (busy) begin
            // New starts are ignored while an op is in flight.
            if (count_q == CountWidth'(1)) begin
                busy    <= 1'b0;
                count_q <= '0;
                if (pend_wr_q) begin
                    hi <= hi_pend_q;
                    lo <= lo_pend_q;
                end
            end else begin
                count_q <= count_q - CountWidth'(1);
            end
        end else if (start) begin
            if (md_is_long(op)) begin
                hi_pend_q <= res_hi;
                lo_pend_q <= res_lo;
                pend_wr_q <= res_wr;
                count_q   <= res_count;
                busy      <= 1'b1;
            end else if (op == MdMthi) begin
                hi <= a;
            end else if (op == MdMtlo) begin
                lo <= a;
            end
        end
    end

endmodule
